divider_arbiter: RTL and testbench
==================================

DIVIDER_ARBITER -- requirements
Module: divider_arbiter

Interface
REQ-001 Parameter: NREQ, default 2 (legal 2..4), number of requesters sharing the one divider.
REQ-002 Parameter: WIDTH, default 16, operand and result width.
REQ-003 Parameter: TIMEOUT, default 255, maximum cycles allowed in START plus WAIT_READY.
REQ-004 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-006 Port: req  in  NREQ  level request per requester, held until its done pulse.
REQ-007 Port: req_a  in  NREQ*WIDTH  dividend, requester i at bits [i*WIDTH +: WIDTH].
REQ-008 Port: req_b  in  NREQ*WIDTH  divisor, same packing as req_a.
REQ-009 Port: grant  out  NREQ  one-hot or zero; the requester currently owning the divider.
REQ-010 Port: done  out  NREQ  one-cycle completion pulse to the granted requester.
REQ-011 Port: res  out  WIDTH  quotient; valid in the cycle done is high, held until the next done.
REQ-012 Port: err  out  1  one-cycle pulse coincident with done on timeout or divide-by-zero.
REQ-013 Port: div_start  out  1  start-division strobe to the divider.
REQ-014 Port: div_a, div_b  out  WIDTH each  dividend and divisor to the divider.
REQ-015 Port: div_busy, div_ready, div_res  in  1/1/WIDTH  divider busy flag, result-ready flag, quotient.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, START, WAIT_READY, DONE; all outputs registered.
REQ-017 IDLE: if any req bit is set, the block SHALL select the winner round-robin, starting the search at (last winner + 1) mod NREQ, and enter ISSUE next cycle.
REQ-018 On entering ISSUE the block SHALL set grant to the winner and latch that requester's operands into div_a/div_b; these SHALL remain stable until IDLE is re-entered.
REQ-019 ISSUE with latched divisor == 0: the block SHALL skip the divider, load res = all ones, and enter DONE with err.
REQ-020 ISSUE with div_busy == 0: the block SHALL assert div_start and enter START; while div_busy == 1 it SHALL remain in ISSUE with div_start low.
REQ-021 START: div_start SHALL stay high until div_busy is sampled 1, then drop, with the FSM entering WAIT_READY.
REQ-022 WAIT_READY: on div_ready == 1 the block SHALL capture div_res into res and enter DONE.
REQ-023 A timeout counter SHALL clear on entering START and increment each cycle in START or WAIT_READY.
REQ-024 On reaching TIMEOUT the block SHALL drop div_start, load res = all ones, and enter DONE with err.
REQ-025 DONE lasts exactly one cycle: done[winner] = 1, the round-robin pointer updates to the winner, and the FSM returns to IDLE.
REQ-026 grant SHALL be cleared in the first IDLE cycle after DONE; the fastest next grant is two cycles after done.
REQ-027 A requester dropping req mid-operation SHALL NOT abort the operation; done still pulses.
REQ-028 Simultaneous requests SHALL be resolved only by the round-robin pointer; no requester waits more than NREQ-1 operations.
REQ-029 Requests arriving outside IDLE SHALL be held pending, never lost or reordered beyond round-robin.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, with grant, done, err, div_start, res, div_a, div_b, the timeout counter and the pointer all set to 0.
REQ-031 An operation interrupted by reset SHALL produce no done pulse; after release, pending req levels are re-arbitrated from pointer 0.

Verification
REQ-032 Single request: req=01, a=740, b=10; the divider sets busy 2 cycles after start and ready 16 cycles later with res=74. Required: done=01 with res=74 and err=0.
REQ-033 Contention: req=11 held continuously. Required: grants alternate 01, 10, 01, with each grant starting 2 cycles after the previous done.
REQ-034 Divide by zero: b=0. Required: div_start never asserts; done and err pulse with res=FFFF in the cycle after ISSUE.
REQ-035 Divider stuck: div_ready is never asserted. Required: done and err at TIMEOUT=255 cycles after START is entered, res=FFFF, and div_start low.
REQ-036 Busy at issue: div_busy=1 for 5 cycles in ISSUE. Required: div_start stays low until busy drops, then asserts.
REQ-037 Reset in WAIT_READY: drive rst_n low. Required: all outputs are 0 asynchronously and no done follows.

Source files
------------

// File: rtl/divider_arbiter.sv
// divider_arbiter
//   Shares one iterative divider between NREQ requesters. A round-robin
//   arbiter picks a requester in IDLE, the FSM hands that requester's
//   operands to the divider, waits for the result (or times out / skips a
//   divide-by-zero) and returns a one-cycle done pulse with the quotient.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   req[NREQ]            level request per requester, held until its done
//   req_a/req_b          packed dividend/divisor, requester i at [i*WIDTH +: WIDTH]
//   grant[NREQ]          one-hot owner of the divider (zero when idle)
//   done[NREQ]           one-cycle completion pulse to the owner
//   res                  quotient, valid with done and held until the next done
//   err                  pulses with done on timeout or divide-by-zero
//   div_start            start strobe to the divider
//   div_a, div_b         latched operands driven to the divider
//   div_busy, div_ready  divider status; div_res is its quotient

module divider_arbiter #(
    parameter int NREQ    = 2,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic [WIDTH-1:0]      res,
    output logic                  err,
    output logic                  div_start,
    output logic [WIDTH-1:0]      div_a,
    output logic [WIDTH-1:0]      div_b,
    input  logic                  div_busy,
    input  logic                  div_ready,
    input  logic [WIDTH-1:0]      div_res
);

    localparam int PW  = $clog2(NREQ);
    localparam int PW1 = PW + 1;
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam logic [PW1-1:0]  NREQ_W   = PW1'(NREQ);
    localparam logic [PW1-1:0]  LAST_IDX = PW1'(NREQ - 1);
    localparam logic [TW-1:0]   T_LAST   = TW'(TIMEOUT - 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t            state_r, state_n;
    logic [NREQ-1:0]   grant_r, grant_n;
    logic [NREQ-1:0]   done_r, done_n;
    logic [WIDTH-1:0]  res_r, res_n;
    logic              err_r, err_n;
    logic              div_start_r, div_start_n;
    logic [WIDTH-1:0]  div_a_r, div_a_n;
    logic [WIDTH-1:0]  div_b_r, div_b_n;
    logic [TW-1:0]     tcnt_r, tcnt_n;
    logic [PW-1:0]     ptr_r, ptr_n;      // last winner
    logic              first_r, first_n;  // no winner since reset: search from 0
    logic [PW-1:0]     win_r, win_n;

    logic [PW1-1:0]    start_s;
    logic [PW1-1:0]    idx_s;
    logic [PW-1:0]     win_s;
    logic              any_s;

    // Round-robin search: first set req bit at or after the start index, wrapping.
    always_comb begin
        start_s = '0;
        idx_s   = '0;
        win_s   = '0;
        any_s   = 1'b0;
        if (first_r) begin
            start_s = '0;
        end else if ({1'b0, ptr_r} == LAST_IDX) begin
            start_s = '0;
        end else begin
            start_s = {1'b0, ptr_r} + PW1'(1);
        end
        for (int k = 0; k < NREQ; k++) begin
            idx_s = start_s + PW1'(k);
            if (idx_s >= NREQ_W) begin
                idx_s = idx_s - NREQ_W;
            end else begin
                idx_s = idx_s;
            end
            if (!any_s && req[idx_s[PW-1:0]]) begin
                any_s = 1'b1;
                win_s = idx_s[PW-1:0];
            end else begin
                any_s = any_s;
            end
        end
    end

    // Next-state and next-output logic; every output is a registered copy.
    always_comb begin
        state_n     = state_r;
        grant_n     = grant_r;
        done_n      = '0;
        res_n       = res_r;
        err_n       = 1'b0;
        div_start_n = 1'b0;
        div_a_n     = div_a_r;
        div_b_n     = div_b_r;
        tcnt_n      = tcnt_r;
        ptr_n       = ptr_r;
        first_n     = first_r;
        win_n       = win_r;
        case (state_r)
            ST_IDLE: begin
                if (any_s) begin
                    state_n = ST_ISSUE;
                    win_n   = win_s;
                    grant_n = ONE_HOT0 << win_s;
                    div_a_n = req_a[int'(win_s) * WIDTH +: WIDTH];
                    div_b_n = req_b[int'(win_s) * WIDTH +: WIDTH];
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (div_b_r == {WIDTH{1'b0}}) begin
                    // Divide-by-zero never reaches the divider.
                    res_n   = {WIDTH{1'b1}};
                    err_n   = 1'b1;
                    done_n  = grant_r;
                    state_n = ST_DONE;
                end else if (!div_busy) begin
                    div_start_n = 1'b1;
                    tcnt_n      = '0;
                    state_n     = ST_START;
                end else begin
                    state_n = ST_ISSUE;
                end
            end
            ST_START: begin
                // Timeout wins so the counter can never run past its limit.
                if (tcnt_r >= T_LAST) begin
                    res_n   = {WIDTH{1'b1}};
                    err_n   = 1'b1;
                    done_n  = grant_r;
                    state_n = ST_DONE;
                end else if (div_busy) begin
                    tcnt_n  = tcnt_r + TW'(1);
                    state_n = ST_WAIT;
                end else begin
                    div_start_n = 1'b1;
                    tcnt_n      = tcnt_r + TW'(1);
                end
            end
            ST_WAIT: begin
                if (div_ready) begin
                    res_n   = div_res;
                    done_n  = grant_r;
                    state_n = ST_DONE;
                end else if (tcnt_r >= T_LAST) begin
                    res_n   = {WIDTH{1'b1}};
                    err_n   = 1'b1;
                    done_n  = grant_r;
                    state_n = ST_DONE;
                end else begin
                    tcnt_n = tcnt_r + TW'(1);
                end
            end
            ST_DONE: begin
                grant_n = '0;
                ptr_n   = win_r;
                first_n = 1'b0;
                state_n = ST_IDLE;
            end
            default: begin
                grant_n = '0;
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            grant_r     <= '0;
            done_r      <= '0;
            res_r       <= '0;
            err_r       <= 1'b0;
            div_start_r <= 1'b0;
            div_a_r     <= '0;
            div_b_r     <= '0;
            tcnt_r      <= '0;
            ptr_r       <= '0;
            first_r     <= 1'b1;
            win_r       <= '0;
        end else begin
            state_r     <= state_n;
            grant_r     <= grant_n;
            done_r      <= done_n;
            res_r       <= res_n;
            err_r       <= err_n;
            div_start_r <= div_start_n;
            div_a_r     <= div_a_n;
            div_b_r     <= div_b_n;
            tcnt_r      <= tcnt_n;
            ptr_r       <= ptr_n;
            first_r     <= first_n;
            win_r       <= win_n;
        end
    end

    assign grant     = grant_r;
    assign done      = done_r;
    assign res       = res_r;
    assign err       = err_r;
    assign div_start = div_start_r;
    assign div_a     = div_a_r;
    assign div_b     = div_b_r;

endmodule

// File: tb/tb_divider_arbiter.sv
// tb_divider_arbiter
//   Directed scenarios for the documented cases plus a randomized phase.
//   A transaction-level model (round-robin pick from the request levels,
//   quotient or all-ones from the latched operands) is compared against the
//   DUT on every negative clock edge. A simple divider model responds to
//   div_start with busy after 2 cycles and ready 16 cycles after that.

module tb_divider_arbiter;

    localparam int NREQ    = 3;
    localparam int W       = 16;
    localparam int TIMEOUT = 255;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*W-1:0] req_a = '0;
    logic [NREQ*W-1:0] req_b = '0;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   done;
    logic [W-1:0]      res;
    logic              err;
    logic              div_start;
    logic [W-1:0]      div_a;
    logic [W-1:0]      div_b;
    logic              div_busy;
    logic              div_ready = 1'b0;
    logic [W-1:0]      div_res = '0;

    logic busy_m = 1'b0;
    logic busy_ext = 1'b0;
    bit   stuck = 1'b0;
    bit   drv_en = 1'b0;
    bit   raise_en = 1'b0;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    // model state
    logic [NREQ-1:0]   p_req = '0;
    logic [NREQ-1:0]   p_grant = '0;
    logic [NREQ*W-1:0] p_a = '0;
    logic [NREQ*W-1:0] p_b = '0;
    bit                m_first = 1'b1;
    int                m_last = 0;
    int                m_w = 0;
    logic [W-1:0]      m_a = '0;
    logic [W-1:0]      m_b = '0;
    logic [W-1:0]      m_res = '0;
    int                wait_ops [NREQ];

    // divider model state
    int           dv_t = -1;
    logic [W-1:0] dv_a = '0;
    logic [W-1:0] dv_b = '0;

    divider_arbiter #(.NREQ(NREQ), .WIDTH(W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_a     (req_a),
        .req_b     (req_b),
        .grant     (grant),
        .done      (done),
        .res       (res),
        .err       (err),
        .div_start (div_start),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_busy  (div_busy),
        .div_ready (div_ready),
        .div_res   (div_res)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign div_busy = busy_m | busy_ext;

    // Divider: busy 2 cycles after start is seen, ready 16 cycles after busy.
    always @(posedge clk) begin
        #1;
        if (!rst_n || grant == '0) begin
            dv_t      = -1;
            busy_m    = 1'b0;
            div_ready = 1'b0;
        end else begin
            div_ready = 1'b0;
            if (dv_t < 0) begin
                if (div_start) begin
                    dv_t = 0;
                    dv_a = div_a;
                    dv_b = div_b;
                end
            end else begin
                dv_t++;
                if (dv_t == 2) busy_m = 1'b1;
                if (dv_t == 18 && !stuck) begin
                    busy_m    = 1'b0;
                    div_ready = 1'b1;
                    div_res   = dv_a / dv_b;
                    dv_t      = -1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        int n = 0;
        while (done == '0 && n < budget) begin
            tick();
            n++;
        end
        check("wait_done_bound", 64'(done != '0), 64'd1);
        dcyc = cyc;
    endtask

    task automatic wait_grant(input int budget, output int gcyc);
        int n = 0;
        while (grant != '0 && n < budget) begin
            tick();
            n++;
        end
        while (grant == '0 && n < budget) begin
            tick();
            n++;
        end
        check("wait_grant_bound", 64'(grant != '0), 64'd1);
        gcyc = cyc;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_grant"}, 64'(grant), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_div_start"}, 64'(div_start), 64'd0);
        check({tag, "_res"}, 64'(res), 64'd0);
        check({tag, "_div_a"}, 64'(div_a), 64'd0);
        check({tag, "_div_b"}, 64'(div_b), 64'd0);
    endtask

    // Round-robin: first requester at or after (last+1) mod NREQ, or 0 after reset.
    function automatic int rr_model(input logic [NREQ-1:0] r, input int last, input bit first);
        int start;
        start = first ? 0 : (last + 1) % NREQ;
        for (int k = 0; k < NREQ; k++) begin
            if (r[(start + k) % NREQ]) return (start + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic compare_loop();
        int w;
        logic [NREQ-1:0] eg;
        logic [W-1:0] exp_res;
        logic exp_err;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_first = 1'b1;
                m_last  = 0;
                m_res   = '0;
                p_grant = '0;
                p_req   = '0;
                for (int i = 0; i < NREQ; i++) wait_ops[i] = 0;
            end else begin
                check("grant_onehot0", 64'($onehot0(grant)), 64'd1);
                if (grant != '0 && p_grant == '0) begin
                    w  = rr_model(p_req, m_last, m_first);
                    eg = '0;
                    if (w >= 0) begin
                        eg[w] = 1'b1;
                        m_w = w;
                        m_a = p_a[w*W +: W];
                        m_b = p_b[w*W +: W];
                    end
                    check("grant_rr", 64'(grant), 64'(eg));
                end
                if (grant != '0) begin
                    check("div_a_latched", 64'(div_a), 64'(m_a));
                    check("div_b_latched", 64'(div_b), 64'(m_b));
                    if (m_b == '0) check("no_start_div0", 64'(div_start), 64'd0);
                end else begin
                    check("idle_done", 64'(done), 64'd0);
                    check("idle_start", 64'(div_start), 64'd0);
                end
                if (done != '0) begin
                    check("done_target", 64'(done), 64'(grant));
                    if (m_b == '0 || stuck) begin
                        exp_res = '1;
                        exp_err = 1'b1;
                    end else begin
                        exp_res = m_a / m_b;
                        exp_err = 1'b0;
                    end
                    check("done_res", 64'(res), 64'(exp_res));
                    check("done_err", 64'(err), 64'(exp_err));
                    m_res   = exp_res;
                    m_last  = m_w;
                    m_first = 1'b0;
                    for (int i = 0; i < NREQ; i++) begin
                        if (i == m_w) begin
                            wait_ops[i] = 0;
                        end else if (req[i]) begin
                            wait_ops[i]++;
                            check("rr_fairness", 64'(wait_ops[i] <= NREQ - 1), 64'd1);
                        end
                    end
                end else begin
                    check("err_quiet", 64'(err), 64'd0);
                    check("res_hold", 64'(res), 64'(m_res));
                end
                p_grant = grant;
                p_req   = req;
                p_a     = req_a;
                p_b     = req_b;
            end
        end
    endtask

    task automatic driver_loop();
        forever begin
            @(posedge clk);
            #1;
            if (drv_en) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (req[i] && done[i]) begin
                        req[i] = 1'b0;
                    end else if (!req[i] && raise_en && $urandom_range(0, 3) == 0) begin
                        req_a[i*W +: W] = 16'($urandom_range(0, 65535));
                        if ($urandom_range(0, 7) == 0)
                            req_b[i*W +: W] = 16'd0;
                        else if ($urandom_range(0, 1) == 0)
                            req_b[i*W +: W] = 16'($urandom_range(1, 255));
                        else
                            req_b[i*W +: W] = 16'($urandom_range(1, 65535));
                        req[i] = 1'b1;
                    end
                end
            end
        end
    endtask

    initial begin
        int n, gc, dc, st, c0;
        bit any_start;
        logic [NREQ-1:0] exp_seq [3];
        exp_seq[0] = 3'b001;
        exp_seq[1] = 3'b010;
        exp_seq[2] = 3'b001;
        for (int i = 0; i < NREQ; i++) wait_ops[i] = 0;

        fork
            compare_loop();
            driver_loop();
        join_none

        // reset state
        tick(); tick(); tick();
        check_outputs_zero("reset");
        rst_n = 1'b1;
        tick();

        // single request 740/10
        set_op(0, 16'd740, 16'd10);
        req = 3'b001;
        c0 = cyc;
        wait_done(60, dc);
        check("single_done", 64'(done), 64'h1);
        check("single_res", 64'(res), 64'd74);
        check("single_err", 64'(err), 64'd0);
        check("single_latency", 64'(dc - c0), 64'd21);
        req = '0;
        tick(); tick();

        // contention from a fresh reset: 01, 10, 01, two cycles after each done
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        set_op(0, 16'd300, 16'd3);
        set_op(1, 16'd1000, 16'd10);
        req = 3'b011;
        dc = 0;
        for (int k = 0; k < 3; k++) begin
            wait_grant(40, gc);
            check("contention_grant", 64'(grant), 64'(exp_seq[k]));
            if (k > 0) check("contention_gap", 64'(gc - dc), 64'd2);
            wait_done(60, dc);
        end
        req = '0;
        tick(); tick();

        // divide by zero
        set_op(1, 16'd1234, 16'd0);
        req = 3'b010;
        any_start = 1'b0;
        gc = -1;
        n = 0;
        while (done == '0 && n < 20) begin
            tick();
            n++;
            if (div_start) any_start = 1'b1;
            if (grant != '0 && gc < 0) gc = cyc;
        end
        check("div0_bound", 64'(done != '0), 64'd1);
        check("div0_latency", 64'(cyc - gc), 64'd1);
        check("div0_done", 64'(done), 64'h2);
        check("div0_res", 64'(res), 64'hFFFF);
        check("div0_err", 64'(err), 64'd1);
        check("div0_no_start", 64'(any_start), 64'd0);
        req = '0;
        tick(); tick();

        // divider never ready
        stuck = 1'b1;
        set_op(0, 16'd5, 16'd1);
        req = 3'b001;
        st = -1;
        n = 0;
        while (done == '0 && n < 400) begin
            tick();
            n++;
            if (div_start && st < 0) st = cyc;
        end
        check("stuck_bound", 64'(done != '0), 64'd1);
        check("stuck_latency", 64'(cyc - st), 64'd255);
        check("stuck_res", 64'(res), 64'hFFFF);
        check("stuck_err", 64'(err), 64'd1);
        check("stuck_start_low", 64'(div_start), 64'd0);
        req = '0;
        tick();
        stuck = 1'b0;
        tick();

        // busy at issue for 5 cycles
        busy_ext = 1'b1;
        set_op(0, 16'd100, 16'd7);
        req = 3'b001;
        wait_grant(10, gc);
        for (int k = 0; k < 5; k++) begin
            check("busy_hold_start", 64'(div_start), 64'd0);
            if (k < 4) tick();
        end
        busy_ext = 1'b0;
        tick();
        check("busy_release_start", 64'(div_start), 64'd1);
        wait_done(60, dc);
        check("busy_res", 64'(res), 64'd14);
        check("busy_err", 64'(err), 64'd0);
        req = '0;
        tick(); tick();

        // requester drops req mid-operation
        set_op(1, 16'd50, 16'd5);
        req = 3'b010;
        wait_grant(10, gc);
        tick(); tick(); tick();
        req = '0;
        wait_done(60, dc);
        check("drop_done", 64'(done), 64'h2);
        check("drop_res", 64'(res), 64'd10);
        tick(); tick();

        // reset while waiting for the divider
        set_op(0, 16'd9, 16'd3);
        req = 3'b001;
        n = 0;
        while (!div_start && n < 20) begin
            tick();
            n++;
        end
        n = 0;
        while (div_start && n < 20) begin
            tick();
            n++;
        end
        check("reach_wait", 64'(div_start == 1'b0 && grant != '0), 64'd1);
        tick(); tick();
        #2;
        rst_n = 1'b0;
        req = '0;
        #1;
        check_outputs_zero("async_reset");
        tick(); tick();
        rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            check("no_done_after_reset", 64'(done), 64'd0);
        end

        // randomized traffic
        drv_en = 1'b1;
        raise_en = 1'b1;
        repeat (3000) tick();
        raise_en = 1'b0;
        n = 0;
        while (req != '0 && n < 4000) begin
            tick();
            n++;
        end
        check("drain", 64'(req == '0), 64'd1);
        drv_en = 1'b0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
